// File: rtl/ccff_pkg.sv
// ============================================================================
// ccff_pkg : shared types and constants for the configuration-chain programmer
// Revision : 1.0
// ============================================================================
`default_nettype none

package ccff_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_SHIFT  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  // Bit order of each byte as it leaves the shift register.
  localparam bit MSB_FIRST = 1'b1;

  function automatic int bytes_needed(input int chain_len, input int data_w);
    return (chain_len + data_w - 1) / data_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ccff_ser.sv
// ============================================================================
// ccff_ser : one-byte holding buffer, bit shift register and cfg_ready logic
// Revision : 1.0
// ============================================================================
`default_nettype none

module ccff_ser
  import ccff_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NBYTES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_load,
  input  logic              take,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              bit_avail,
  output logic              bit_out
);

  localparam int SCW = $clog2(DATA_W + 1);
  localparam int BCW = $clog2(NBYTES + 1);
  localparam logic [SCW-1:0] SR_RELOAD = SCW'(DATA_W - 1);
  localparam logic [BCW-1:0] BYTES_ALL = BCW'(NBYTES);

  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] src;
  logic [SCW-1:0]    sr_cnt;
  logic [BCW-1:0]    byte_cnt;
  logic              hold_full;
  logic              sr_empty;
  logic              accept;
  logic              bypass;

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  assign sr_empty  = (sr_cnt == '0);
  // Stop asking for bytes once every byte the chain needs has arrived.
  assign cfg_ready = in_load && !hold_full && (byte_cnt != BYTES_ALL);
  assign accept    = cfg_valid && cfg_ready;
  // A byte arriving while both stages are empty feeds the chain directly.
  assign bypass    = take && sr_empty && !hold_full;
  assign bit_avail = !sr_empty || hold_full || accept;

  always_comb begin
    src = sr;
    if (sr_empty) begin
      src = hold_full ? hold : cfg_data;
    end
  end

  assign bit_out = MSB_FIRST ? src[DATA_W-1] : src[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      hold      <= '0;
      sr_cnt    <= '0;
      byte_cnt  <= '0;
      hold_full <= 1'b0;
    end else if (flush) begin
      sr        <= '0;
      hold      <= '0;
      sr_cnt    <= '0;
      byte_cnt  <= '0;
      hold_full <= 1'b0;
    end else begin
      if (accept) begin
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (accept && !bypass) begin
        hold      <= cfg_data;
        hold_full <= 1'b1;
      end
      if (take) begin
        sr <= advance(src);
        if (sr_empty) begin
          sr_cnt <= SR_RELOAD;
          if (hold_full) begin
            hold_full <= 1'b0;
          end
        end else begin
          sr_cnt <= sr_cnt - 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ccff_programmer.sv
// ============================================================================
// ccff_programmer : streams a byte bitstream into a configuration FF chain.
// Optional readback of the previous chain contents: define CCFF_READBACK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ccff_programmer
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 10,
  parameter int DATA_W    = 8
) (
  input  logic                 prog_clk,
  input  logic                 prog_rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DATA_W-1:0]    cfg_data,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic                 ccff_head,
  output logic                 ccff_clk_en,
  input  logic                 ccff_tail,
  output logic                 busy,
`ifdef CCFF_READBACK_EN
  output logic [CHAIN_LEN-1:0] rb_data,
  output logic                 rb_valid,
`endif
  output logic                 done
);

  localparam int CW     = $clog2(CHAIN_LEN + 1);
  localparam int NBYTES = bytes_needed(CHAIN_LEN, DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic          in_load;
  logic          flush;
  logic          take;
  logic          accept;
  logic          bit_avail;
  logic          bit_out;

  assign in_load = (state == S_FILL) || (state == S_SHIFT);
  assign flush   = abort || (state == S_IDLE) || (state == S_FINISH);
  assign take    = (state == S_SHIFT) && !abort && bit_avail;
  assign accept  = cfg_valid && cfg_ready;

  ccff_ser #(
    .DATA_W (DATA_W),
    .NBYTES (NBYTES)
  ) u_ser (
    .clk       (prog_clk),
    .rst_n     (prog_rst_n),
    .flush     (flush),
    .in_load   (in_load),
    .take      (take),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .bit_avail (bit_avail),
    .bit_out   (bit_out)
  );

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      ccff_head   <= 1'b0;
      ccff_clk_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      ccff_clk_en <= 1'b0;
      done        <= 1'b0;
      if (abort) begin
        state   <= S_IDLE;
        busy    <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state   <= S_FILL;
              busy    <= 1'b1;
              bit_cnt <= '0;
            end
          end
          S_FILL: begin
            if (accept) begin
              state <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            // Without a bit to send the chain clock stays off and head holds.
            if (take) begin
              ccff_head   <= bit_out;
              ccff_clk_en <= 1'b1;
              bit_cnt     <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                state <= S_FINISH;
              end
            end
          end
          S_FINISH: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef CCFF_READBACK_EN
  // The tail is sampled on the same edge the chain captures, so after a full
  // load rb_data holds what the chain contained before it.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= (state == S_FINISH) && !abort;
    end
  end

  if (CHAIN_LEN == 1) begin : g_rb_single
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
        rb_data <= '0;
      end else if (ccff_clk_en) begin
        rb_data <= ccff_tail;
      end
    end
  end else begin : g_rb_chain
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
        rb_data <= '0;
      end else if (ccff_clk_en) begin
        rb_data <= {ccff_tail, rb_data[CHAIN_LEN-1:1]};
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule

`default_nettype wire
